sweep_ctrl: RTL and testbench

Sequencer that drives the team's 4-bit up/down counter (load / up_down / enable / d_in, registered count) to produce a programmed triangle sweep between a low and a high bound, repeated a programmed number of times. It sits between a host-side start/abort handshake and one counter instance. It owns the counter's control pins and observes the counter's registered output. It adds no storage of the count value itself.

---
 rtl/sweep_ctrl_if.sv | 32 +++
 rtl/sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_sweep_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sweep_ctrl_if.sv
// Host and counter signals of the triangle-sweep sequencer.
// slave = the sequencer, master = host/counter side driving requests and cnt_q.
`timescale 1ns/1ps
interface sweep_ctrl_if #(
  parameter int W  = 4,
  parameter int SW = 8
);
  logic          start;
  logic          abort;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic [SW-1:0] sweeps;
  logic [W-1:0]  cnt_q;
  logic          cnt_load;
  logic          cnt_up_down;
  logic          cnt_enable;
  logic [W-1:0]  cnt_d;
  logic          busy;
  logic          done;
  logic          err;
  logic [SW-1:0] sweeps_left;

  modport slave (
    input  start, abort, lo, hi, sweeps, cnt_q,
    output cnt_load, cnt_up_down, cnt_enable, cnt_d, busy, done, err, sweeps_left
  );

  modport master (
    output start, abort, lo, hi, sweeps, cnt_q,
    input  cnt_load, cnt_up_down, cnt_enable, cnt_d, busy, done, err, sweeps_left
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Drives an external up/down counter through lo->hi->lo triangle sweeps; 1-cycle load then 1 step/cycle.
// No backpressure: start is taken only in IDLE, abort ends the run at once, counter controls drop with rst.
`timescale 1ns/1ps
module sweep_ctrl #(
  parameter int W  = 4,
  parameter int SW = 8
) (
  input  logic        clk,
  input  logic        rst,
  sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] left_q, left_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          load_c, enable_c, up_down_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      left_q  <= left_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    left_d    = left_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_c    = 1'b0;
    enable_c  = 1'b0;
    up_down_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if ((bus.lo < bus.hi) && (bus.sweeps != '0)) begin
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            left_d  = bus.sweeps;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load_c  = 1'b1;
        state_d = S_UP;
      end
      S_UP: begin
        enable_c  = 1'b1;
        up_down_c = (bus.cnt_q != hi_q);
        // The turnaround edge already steps down, so hi is seen for one cycle only.
        if (bus.cnt_q == hi_q) begin
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (bus.cnt_q != lo_q) begin
          enable_c = 1'b1;
        end else if (left_q > SW'(1)) begin
          left_d    = left_q - SW'(1);
          enable_c  = 1'b1;
          up_down_c = 1'b1;
          state_d   = S_UP;
        end else begin
          left_d  = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort freezes the counter where it stands and suppresses the done pulse.
    if (bus.abort && (state_q != S_IDLE)) begin
      load_c    = 1'b0;
      enable_c  = 1'b0;
      up_down_c = 1'b0;
      done_d    = 1'b0;
      state_d   = S_IDLE;
    end
  end

  // Gated by rst so the shared counter stops on the same edge the sequencer resets.
  assign bus.cnt_load    = load_c    & ~rst;
  assign bus.cnt_enable  = enable_c  & ~rst;
  assign bus.cnt_up_down = up_down_c & ~rst;
  assign bus.cnt_d       = lo_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.sweeps_left = left_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: drives a behavioural 4-bit counter and checks against a precomputed sweep trajectory.
`timescale 1ns/1ps
module tb_sweep_ctrl;
  localparam int W  = 4;
  localparam int SW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cnt_rst = 1'b1;
  logic [W-1:0] cnt_reg;
  int           checks = 0;
  int           errors = 0;
  int           last_lo = 0;

  sweep_ctrl_if #(.W(W), .SW(SW)) bus ();

  sweep_ctrl #(.W(W), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The counter this block is meant to drive, with its own reset.
  always_ff @(posedge clk) begin
    if (cnt_rst)              cnt_reg <= '0;
    else if (bus.cnt_load)    cnt_reg <= bus.cnt_d;
    else if (bus.cnt_enable)  cnt_reg <= bus.cnt_up_down ? cnt_reg + W'(1) : cnt_reg - W'(1);
  end
  assign bus.cnt_q = cnt_reg;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a run and follow it to IDLE; optionally re-pulse start with junk mid-run.
  task automatic run_seq(input int lo, input int hi, input int s, input bit repulse);
    int q[$];
    int n, d, rk, exp_left;
    d = hi - lo;
    q.push_back(lo);
    for (int j = 0; j < s; j++) begin
      for (int v = lo + 1; v <= hi; v++) q.push_back(v);
      for (int v = hi - 1; v >= lo; v--) q.push_back(v);
    end
    n = q.size();
    rk = repulse ? int'($urandom_range(1, n)) : -1;

    bus.lo = W'(lo);
    bus.hi = W'(hi);
    bus.sweeps = SW'(s);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_val("acc_busy", 32'(bus.busy), 1);
    check_val("acc_left", 32'(bus.sweeps_left), s);

    for (int k = 1; k <= n + 2; k++) begin
      step();
      bus.start = 1'b0;
      exp_left = (k < 2) ? s : s - (k - 2) / (2 * d);
      check_val("seq_cnt", 32'(bus.cnt_q), (k <= n) ? q[k-1] : lo);
      check_val("seq_busy", 32'(bus.busy), (k <= n + 1) ? 1 : 0);
      check_val("seq_done", 32'(bus.done), (k == n + 1) ? 1 : 0);
      check_val("seq_left", 32'(bus.sweeps_left), exp_left);
      check_val("seq_err", 32'(bus.err), 0);
      if (k == rk) begin
        bus.start = 1'b1;
        bus.lo = W'($urandom_range(0, 15));
        bus.hi = W'($urandom_range(0, 15));
        bus.sweeps = SW'($urandom_range(0, 255));
      end
    end
    last_lo = lo;
  endtask

  task automatic try_bad(input int lo, input int hi, input int s);
    bus.lo = W'(lo);
    bus.hi = W'(hi);
    bus.sweeps = SW'(s);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_val("bad_err", 32'(bus.err), 1);
    check_val("bad_busy", 32'(bus.busy), 0);
    check_val("bad_load", 32'(bus.cnt_load), 0);
    step();
    check_val("bad_err_clr", 32'(bus.err), 0);
    check_val("bad_busy2", 32'(bus.busy), 0);
    check_val("bad_load2", 32'(bus.cnt_load), 0);
    check_val("bad_keep_lo", 32'(bus.cnt_d), last_lo);
  endtask

  initial begin
    int lo, hi, s;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    bus.sweeps = '0;
    repeat (3) step();
    rst = 1'b0;
    cnt_rst = 1'b0;

    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_done", 32'(bus.done), 0);
    check_val("rst_err", 32'(bus.err), 0);
    check_val("rst_load", 32'(bus.cnt_load), 0);
    check_val("rst_en", 32'(bus.cnt_enable), 0);
    check_val("rst_ud", 32'(bus.cnt_up_down), 0);
    check_val("rst_d", 32'(bus.cnt_d), 0);
    check_val("rst_left", 32'(bus.sweeps_left), 0);

    run_seq(2, 5, 1, 1'b0);
    repeat (10) begin
      step();
      check_val("hold_cnt", 32'(bus.cnt_q), 2);
      check_val("hold_busy", 32'(bus.busy), 0);
    end

    run_seq(0, 15, 2, 1'b0);

    try_bad(6, 6, 3);
    try_bad(9, 3, 3);
    try_bad(2, 5, 0);

    // Abort in the down phase of the first sweep when the count reaches 8.
    bus.lo = W'(3);
    bus.hi = W'(12);
    bus.sweeps = SW'(3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    check_val("abort_pre_cnt", 32'(bus.cnt_q), 8);
    check_val("abort_pre_dir", 32'(bus.cnt_up_down), 0);
    check_val("abort_pre_en", 32'(bus.cnt_enable), 1);
    bus.abort = 1'b1;
    #1;
    check_val("abort_en", 32'(bus.cnt_enable), 0);
    check_val("abort_load", 32'(bus.cnt_load), 0);
    step();
    bus.abort = 1'b0;
    check_val("abort_busy", 32'(bus.busy), 0);
    check_val("abort_done", 32'(bus.done), 0);
    check_val("abort_cnt", 32'(bus.cnt_q), 8);
    step();
    check_val("abort_done2", 32'(bus.done), 0);
    check_val("abort_cnt2", 32'(bus.cnt_q), 8);
    run_seq(4, 9, 1, 1'b0);

    // start and abort together in IDLE: abort wins.
    bus.lo = W'(1);
    bus.hi = W'(4);
    bus.sweeps = SW'(1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_val("sa_busy", 32'(bus.busy), 0);
    check_val("sa_err", 32'(bus.err), 0);
    check_val("sa_load", 32'(bus.cnt_load), 0);
    step();
    check_val("sa_busy2", 32'(bus.busy), 0);

    run_seq(1, 6, 2, 1'b1);
    run_seq(7, 8, 255, 1'b0);

    for (int i = 0; i < 15; i++) begin
      lo = int'($urandom_range(0, 14));
      hi = int'($urandom_range(lo + 1, 15));
      s  = int'($urandom_range(1, 4));
      run_seq(lo, hi, s, 1'($urandom_range(0, 1)));
    end

    // Synchronous reset while counting up through 7.
    bus.lo = W'(2);
    bus.hi = W'(10);
    bus.sweeps = SW'(1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    check_val("rst_pre_cnt", 32'(bus.cnt_q), 7);
    check_val("rst_pre_dir", 32'(bus.cnt_up_down), 1);
    rst = 1'b1;
    step();
    check_val("mrst_busy", 32'(bus.busy), 0);
    check_val("mrst_en", 32'(bus.cnt_enable), 0);
    check_val("mrst_ud", 32'(bus.cnt_up_down), 0);
    check_val("mrst_cnt", 32'(bus.cnt_q), 7);
    check_val("mrst_d", 32'(bus.cnt_d), 0);
    check_val("mrst_left", 32'(bus.sweeps_left), 0);
    rst = 1'b0;
    repeat (5) begin
      step();
      check_val("post_rst_cnt", 32'(bus.cnt_q), 7);
      check_val("post_rst_done", 32'(bus.done), 0);
      check_val("post_rst_busy", 32'(bus.busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
